// File: rtl/data_bus_responder_pkg.sv
// Shared constants and types for the data-memory responder: I/O decode,
// register offsets, CTRL bit positions and the timer register write port.
package data_bus_responder_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IO_SEL_BIT = 31;

  localparam logic [3:0] REG_GPIO_OFS  = 4'h0;
  localparam logic [3:0] REG_COUNT_OFS = 4'h4;
  localparam logic [3:0] REG_CMP_OFS   = 4'h8;
  localparam logic [3:0] REG_CTRL_OFS  = 4'hC;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_PEND_BIT = 1;
  localparam int unsigned CTRL_AUTO_BIT = 2;

  localparam logic [DATA_W-1:0] CMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IO_GPIO  = REG_GPIO_OFS[3:2],
    IO_COUNT = REG_COUNT_OFS[3:2],
    IO_CMP   = REG_CMP_OFS[3:2],
    IO_CTRL  = REG_CTRL_OFS[3:2]
  } io_reg_e;

  typedef struct packed {
    logic              en;
    io_reg_e           sel;
    logic [DATA_W-1:0] data;
    logic [3:0]        mask;
  } reg_wr_t;

  // Replace only the byte lanes enabled in mask.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [3:0]        mask);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// Single-cycle CPU data-memory bus: request from the core, combinational read back.
interface data_bus_responder_if;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        memWr;
  logic [3:0]  wrMask;
  logic [31:0] memReadData;

  modport master (output memAddr, output memWriteData, output memWr, output wrMask,
                  input memReadData);
  modport slave  (input memAddr, input memWriteData, input memWr, input wrMask,
                  output memReadData);
endinterface

// File: rtl/data_bus_responder_timer.sv
// dbr_timer: prescaled COUNT/CMP timer with CTRL {AUTO,PEND,EN} and registered irq.
// Built only when DBR_TIMER_EN is defined; otherwise reads 0 and irq is tied low.
module dbr_timer
  import data_bus_responder_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  reg_wr_t           wr_i,
  input  io_reg_e           rd_sel_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              irq_o
);

`ifdef DBR_TIMER_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic              en_q, en_d, pend_q, pend_d, auto_q, auto_d, irq_q;
  logic              tick, match, wr_count, wr_cmp, wr_ctrl;

  // Next-state: tick result first, then CPU byte writes override; match set beats W1C.
  always_comb begin
    wr_count = wr_i.en && (wr_i.sel == IO_COUNT);
    wr_cmp   = wr_i.en && (wr_i.sel == IO_CMP);
    wr_ctrl  = wr_i.en && (wr_i.sel == IO_CTRL) && wr_i.mask[0];
    tick     = en_q && (presc_q == PW'(PRESCALE - 1));
    match    = (count_q == cmp_q);

    presc_d = presc_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    auto_d  = auto_q;
    pend_d  = pend_q;

    if (en_q) presc_d = tick ? '0 : presc_q + PW'(1);
    if (wr_ctrl && wr_i.data[CTRL_EN_BIT]) presc_d = '0;

    if (tick) count_d = (match && auto_q) ? '0 : count_q + 32'd1;
    if (wr_count) count_d = merge_bytes(count_d, wr_i.data, wr_i.mask);
    if (wr_cmp)   cmp_d   = merge_bytes(cmp_q, wr_i.data, wr_i.mask);

    if (wr_ctrl) begin
      en_d   = wr_i.data[CTRL_EN_BIT];
      auto_d = wr_i.data[CTRL_AUTO_BIT];
      if (wr_i.data[CTRL_PEND_BIT]) pend_d = 1'b0;
    end
    if (tick && match) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      count_q <= '0;
      cmp_q   <= CMP_RST;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      auto_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      auto_q  <= auto_d;
      irq_q   <= pend_q;
    end
  end

  always_comb begin
    rd_data_o = '0;
    unique case (rd_sel_i)
      IO_COUNT: rd_data_o = count_q;
      IO_CMP:   rd_data_o = cmp_q;
      IO_CTRL:  rd_data_o = {29'b0, auto_q, pend_q, en_q};
      default:  rd_data_o = '0;
    endcase
  end

  assign irq_o = irq_q;
`else
  logic unused_tmr;
  assign unused_tmr = ^{clk, reset, wr_i, rd_sel_i};
  assign rd_data_o  = '0;
  assign irq_o      = 1'b0;
`endif

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory target: RAM (aliased, not reset), GPIO register and dbr_timer.
// Timer presence is selected by the DBR_TIMER_EN macro.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  data_bus_responder_if.slave  bus,
  output logic [DATA_W-1:0]    gpioOut,
  output logic                 irq
);

  localparam int unsigned AW = $clog2(RAM_WORDS);

  logic [DATA_W-1:0] mem_q [RAM_WORDS];
  logic [DATA_W-1:0] gpio_q, gpio_d, tmr_rd;
  logic [AW-1:0]     widx;
  logic              is_io, unused_addr;
  io_reg_e           sel;
  reg_wr_t           tmr_wr;

  assign unused_addr = ^bus.memAddr;

  // Region decode and timer write port.
  always_comb begin
    is_io       = bus.memAddr[IO_SEL_BIT];
    widx        = bus.memAddr[AW+1:2];
    sel         = io_reg_e'(bus.memAddr[3:2]);
    tmr_wr.en   = bus.memWr && is_io;
    tmr_wr.sel  = sel;
    tmr_wr.data = bus.memWriteData;
    tmr_wr.mask = bus.wrMask;
    gpio_d      = gpio_q;
    if (bus.memWr && is_io && (sel == IO_GPIO))
      gpio_d = merge_bytes(gpio_q, bus.memWriteData, bus.wrMask);
  end

  always_ff @(posedge clk) begin
    if (bus.memWr && !is_io) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wrMask[i]) mem_q[widx][8*i +: 8] <= bus.memWriteData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) gpio_q <= '0;
    else       gpio_q <= gpio_d;
  end

  dbr_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_i      (tmr_wr),
    .rd_sel_i  (sel),
    .rd_data_o (tmr_rd),
    .irq_o     (irq)
  );

  assign bus.memReadData = !is_io ? mem_q[widx] : ((sel == IO_GPIO) ? gpio_q : tmr_rd);
  assign gpioOut         = gpio_q;

endmodule
